// File: rtl/if_fetch.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | if_fetch: instruction fetch, one outstanding request, 2-entry output FIFO.  |
// | Optional macro IF_MISALIGN_FAULT_EN. Revision 1.0                           |
// +-----------------------------------------------------------------------------+
module if_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_flag_i,
  input  logic [63:0] jump_addr_i,
  input  logic        hold_flag_i,
  output logic        imem_req_o,
  output logic [63:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic [63:0] inst_addr_o,
  output logic        inst_valid_o,
  output logic        fault_o
);

  localparam logic [31:0] C_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DROP = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] addr;
    logic        fault;
  } entry_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [63:0] r_pc;
  logic [63:0] w_pc_next;
  logic [63:0] r_req_addr;
  entry_t      r_fifo [2];
  logic [1:0]  r_count;
  entry_t      w_push_entry;
  logic        w_push;
  logic        w_pop;
  logic        w_room;
  logic        w_grant;
  logic        w_misaligned;

`ifdef IF_MISALIGN_FAULT_EN
  logic r_fault_done;
  assign w_misaligned = (r_pc[1:0] != 2'b00);
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_pop        = (r_count != 2'd0) && !hold_flag_i && !jump_flag_i;
  // Room is judged after this cycle's pop so a full FIFO being drained can still fetch.
  assign w_room       = (r_count - {1'b0, w_pop}) < 2'd2;
  assign imem_req_o   = (r_state == S_REQ) && w_room && !w_misaligned;
  assign imem_addr_o  = r_pc;
  assign w_grant      = imem_req_o && imem_gnt_i;

  assign inst_valid_o = (r_count != 2'd0);
  assign inst_o       = inst_valid_o ? r_fifo[0].inst : C_NOP;
  assign inst_addr_o  = inst_valid_o ? r_fifo[0].addr : 64'd0;
  assign fault_o      = inst_valid_o && r_fifo[0].fault;

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_push       = 1'b0;
    w_push_entry = '{inst: imem_rdata_i, addr: r_req_addr, fault: 1'b0};
    case (r_state)
      S_IDLE: w_state_next = S_REQ;
      S_REQ: begin
        if (w_grant) begin
          w_state_next = jump_flag_i ? S_DROP : S_WAIT;
          w_pc_next    = r_pc + 64'd4;
        end
`ifdef IF_MISALIGN_FAULT_EN
        else if (w_misaligned && !r_fault_done && w_room) begin
          w_push       = 1'b1;
          w_push_entry = '{inst: C_NOP, addr: r_pc, fault: 1'b1};
        end
`endif
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          w_state_next = S_REQ;
          w_push       = 1'b1;
        end else if (jump_flag_i) begin
          w_state_next = S_DROP;
        end
      end
      S_DROP: if (imem_rvalid_i) w_state_next = S_REQ;
      default: w_state_next = S_IDLE;
    endcase
    // A redirect overrides the sequential pc and discards any response landing now.
    if (jump_flag_i) begin
      w_pc_next = jump_addr_i;
      w_push    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_req_addr <= 64'd0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      if (w_grant) r_req_addr <= r_pc;
    end
  end

  // Head always lives in slot 0; a pop shifts slot 1 down.
  always_ff @(posedge clk) begin
    if (!rst_n || jump_flag_i) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          r_fifo[r_count[0]] <= w_push_entry;
          r_count            <= r_count + 2'd1;
        end
        2'b01: begin
          r_fifo[0] <= r_fifo[1];
          r_count   <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_fifo[0] <= w_push_entry;
          end else begin
            r_fifo[0] <= r_fifo[1];
            r_fifo[1] <= w_push_entry;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef IF_MISALIGN_FAULT_EN
  always_ff @(posedge clk) begin
    if (!rst_n || jump_flag_i) r_fault_done <= 1'b0;
    else if (w_push && (r_state == S_REQ)) r_fault_done <= 1'b1;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_if_fetch: directed and randomized bench for if_fetch with a queue model. |
// | Revision 1.0                                                                |
// +-----------------------------------------------------------------------------+
module tb_if_fetch;

  localparam logic [31:0] C_NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        jump_flag_i = 1'b0;
  logic [63:0] jump_addr_i = 64'd0;
  logic        hold_flag_i = 1'b0;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'd0;
  logic        imem_req_o;
  logic [63:0] imem_addr_o;
  logic [31:0] inst_o;
  logic [63:0] inst_addr_o;
  logic        inst_valid_o;
  logic        fault_o;

  if_fetch #(.RESET_PC(64'h0000_0000_8000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .jump_flag_i  (jump_flag_i),
    .jump_addr_i  (jump_addr_i),
    .hold_flag_i  (hold_flag_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
    .inst_valid_o (inst_valid_o),
    .fault_o      (fault_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory contents are a pure function of the address; 0x80000000 holds 0x00500093.
  function automatic logic [31:0] mem_data(input logic [63:0] a);
    return a[31:0] ^ 32'h8050_0093;
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] addr;
    logic        fault;
  } ent_t;

  ent_t        m_q[$];
  logic [63:0] m_pc = 64'd0;
  logic [63:0] m_pend = 64'd0;
  bit          m_started = 0;
  bit          m_out = 0;
  bit          m_drop = 0;
  bit          m_fdone = 0;
  bit          chk_en = 0;

  function automatic bit m_in_req();
    return m_started && !m_out && !m_drop;
  endfunction

  function automatic bit m_misal();
`ifdef IF_MISALIGN_FAULT_EN
    return m_pc[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_pop_now();
    return (m_q.size() > 0) && !hold_flag_i && !jump_flag_i;
  endfunction

  function automatic bit m_req_now();
    return m_in_req() && !m_misal() && ((m_q.size() - int'(m_pop_now())) < 2);
  endfunction

  always @(posedge clk) begin
    bit pop, grant, fpush;
    if (!rst_n) begin
      m_q.delete();
      m_pc = 64'h0000_0000_8000_0000;
      m_started = 0; m_out = 0; m_drop = 0; m_fdone = 0;
      chk_en = 1;
    end else begin
      pop   = m_pop_now();
      grant = m_req_now() && imem_gnt_i;
      fpush = m_in_req() && m_misal() && !m_fdone && ((m_q.size() - int'(pop)) < 2);
      if (jump_flag_i) begin
        m_q.delete();
        if (m_out) begin
          m_out  = 0;
          m_drop = !imem_rvalid_i;
        end else if (m_drop) begin
          if (imem_rvalid_i) m_drop = 0;
        end else if (grant) begin
          m_drop = 1;
        end
        m_pc = jump_addr_i;
        m_fdone = 0;
      end else begin
        if (pop) void'(m_q.pop_front());
        if (m_out && imem_rvalid_i) begin
          m_q.push_back('{inst: imem_rdata_i, addr: m_pend, fault: 1'b0});
          m_out = 0;
        end else if (m_drop && imem_rvalid_i) begin
          m_drop = 0;
        end
        if (grant) begin
          m_out = 1;
          m_pend = m_pc;
          m_pc = m_pc + 64'd4;
        end
        if (fpush) begin
          m_q.push_back('{inst: C_NOP, addr: m_pc, fault: 1'b1});
          m_fdone = 1;
        end
      end
      m_started = 1;
    end
  end

  // Single compare point against the model, on the inactive edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("req", 64'(imem_req_o), 64'(m_req_now()));
      if (m_req_now()) check("addr", imem_addr_o, m_pc);
      if (m_q.size() > 0) begin
        check("valid", 64'(inst_valid_o), 64'd1);
        check("inst", 64'(inst_o), 64'(m_q[0].inst));
        check("inst_addr", inst_addr_o, m_q[0].addr);
        check("fault", 64'(fault_o), 64'(m_q[0].fault));
      end else begin
        check("valid", 64'(inst_valid_o), 64'd0);
        check("inst", 64'(inst_o), 64'(C_NOP));
        check("inst_addr", inst_addr_o, 64'd0);
        check("fault", 64'(fault_o), 64'd0);
      end
    end
  end

  // ---------------- memory responder ----------------
  bit          mem_g = 0;
  bit          mem_rst = 1;
  logic [63:0] mem_a = 64'd0;
  bit          mem_busy = 0;
  int          mem_wait = 0;
  logic [63:0] mem_addr = 64'd0;
  int          fixed_lat = -1;
  bit          stray_en = 0;

  always @(negedge clk) begin
    mem_g   = imem_req_o && imem_gnt_i;
    mem_a   = imem_addr_o;
    mem_rst = !rst_n;
  end

  always @(posedge clk) begin
    #2;
    if (mem_rst) begin
      mem_busy = 0;
    end else if (mem_g) begin
      mem_busy = 1;
      mem_addr = mem_a;
      mem_wait = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 2));
    end
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = $urandom;
    if (mem_busy) begin
      if (mem_wait == 0) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_data(mem_addr);
        mem_busy      = 0;
      end else begin
        mem_wait--;
      end
    end else if (stray_en && ($urandom_range(0, 1) == 1)) begin
      imem_rvalid_i = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
    stray_en = 0;
  endtask

  task automatic wait_neg();
    @(negedge clk);
  endtask

  // Leaves the caller at the start of the IDLE cycle following one reset cycle.
  task automatic do_reset();
    next_cycle();
    rst_n = 1'b0; jump_flag_i = 1'b0; hold_flag_i = 1'b0; imem_gnt_i = 1'b0;
    stray_en = 1;
    next_cycle();
    rst_n = 1'b1;
    stray_en = 1;
  endtask

  initial begin
    int          got, n, r;
    bit          seen_req;
    logic [63:0] seen [3];
    logic [63:0] base;

    // Reset release then a single zero-latency fetch.
    do_reset();
    imem_gnt_i = 1'b1; fixed_lat = 0;
    wait_neg();
    check("idle_req", 64'(imem_req_o), 64'd0);
    check("reset_valid", 64'(inst_valid_o), 64'd0);
    check("reset_inst", 64'(inst_o), 64'h13);
    next_cycle();
    wait_neg();
    check("first_req", 64'(imem_req_o), 64'd1);
    check("first_addr", imem_addr_o, 64'h8000_0000);
    next_cycle();
    next_cycle();
    wait_neg();
    check("first_valid", 64'(inst_valid_o), 64'd1);
    check("first_inst", 64'(inst_o), 64'h0050_0093);
    check("first_inst_addr", inst_addr_o, 64'h8000_0000);

    // Hold fills the FIFO to two, then release drains in order.
    do_reset();
    hold_flag_i = 1'b1; imem_gnt_i = 1'b1; fixed_lat = 0;
    for (int k = 0; k < 5; k++) next_cycle();
    wait_neg();
    check("full_req", 64'(imem_req_o), 64'd0);
    check("full_head", inst_addr_o, 64'h8000_0000);
    next_cycle();
    wait_neg();
    check("full_req2", 64'(imem_req_o), 64'd0);
    next_cycle();
    hold_flag_i = 1'b0;
    got = 0;
    seen[0] = '0; seen[1] = '0; seen[2] = '0;
    for (int k = 0; k < 10 && got < 3; k++) begin
      wait_neg();
      if (inst_valid_o && !hold_flag_i) begin
        seen[got] = inst_addr_o;
        got++;
      end
      next_cycle();
    end
    check("hold_pops", 64'(got), 64'd3);
    check("hold_pop0", seen[0], 64'h8000_0000);
    check("hold_pop1", seen[1], 64'h8000_0004);
    check("hold_pop2", seen[2], 64'h8000_0008);

    // Redirect during WAIT; stale response three cycles later is dropped.
    do_reset();
    imem_gnt_i = 1'b1; fixed_lat = 3;
    next_cycle();
    next_cycle();
    jump_flag_i = 1'b1; jump_addr_i = 64'h8000_1000;
    next_cycle();
    jump_flag_i = 1'b0;
    n = 0; seen_req = 0;
    for (int k = 0; k < 10; k++) begin
      wait_neg();
      if (imem_req_o) begin
        seen_req = 1;
        break;
      end
      check("drop_empty", 64'(inst_valid_o), 64'd0);
      n++;
      next_cycle();
    end
    check("drop_req_seen", 64'(seen_req), 64'd1);
    check("drop_cycles", 64'(n), 64'd3);
    check("drop_new_addr", imem_addr_o, 64'h8000_1000);
    check("drop_valid", 64'(inst_valid_o), 64'd0);

    // Redirect coincident with rvalid, then redirect under hold.
    do_reset();
    hold_flag_i = 1'b1; imem_gnt_i = 1'b1; fixed_lat = 0;
    next_cycle();
    next_cycle();
    jump_flag_i = 1'b1; jump_addr_i = 64'h8000_2000;
    next_cycle();
    jump_flag_i = 1'b0;
    wait_neg();
    check("jr_valid", 64'(inst_valid_o), 64'd0);
    check("jr_req", 64'(imem_req_o), 64'd1);
    check("jr_addr", imem_addr_o, 64'h8000_2000);
    next_cycle();
    next_cycle();
    imem_gnt_i = 1'b0; jump_flag_i = 1'b1; jump_addr_i = 64'h8000_3000;
    wait_neg();
    check("jh_head", inst_addr_o, 64'h8000_2000);
    next_cycle();
    jump_flag_i = 1'b0;
    wait_neg();
    check("jh_valid", 64'(inst_valid_o), 64'd0);
    check("jh_req", 64'(imem_req_o), 64'd1);
    check("jh_addr", imem_addr_o, 64'h8000_3000);

    // pc wraps past the top of the address space.
    do_reset();
    imem_gnt_i = 1'b1; fixed_lat = 0;
    jump_flag_i = 1'b1; jump_addr_i = 64'hFFFF_FFFF_FFFF_FFFC;
    next_cycle();
    jump_flag_i = 1'b0;
    wait_neg();
    check("wrap_req", 64'(imem_req_o), 64'd1);
    check("wrap_addr", imem_addr_o, 64'hFFFF_FFFF_FFFF_FFFC);
    next_cycle();
    next_cycle();
    wait_neg();
    check("wrap_next_addr", imem_addr_o, 64'd0);
    check("wrap_head", inst_addr_o, 64'hFFFF_FFFF_FFFF_FFFC);

    // Misaligned redirect target.
    do_reset();
    hold_flag_i = 1'b1;
    jump_flag_i = 1'b1; jump_addr_i = 64'h8000_0002;
    next_cycle();
    jump_flag_i = 1'b0;
    next_cycle();
    wait_neg();
`ifdef IF_MISALIGN_FAULT_EN
    check("mis_req", 64'(imem_req_o), 64'd0);
    check("mis_valid", 64'(inst_valid_o), 64'd1);
    check("mis_fault", 64'(fault_o), 64'd1);
    check("mis_inst_addr", inst_addr_o, 64'h8000_0002);
    check("mis_inst", 64'(inst_o), 64'h13);
`else
    check("mis_req", 64'(imem_req_o), 64'd1);
    check("mis_addr", imem_addr_o, 64'h8000_0002);
    check("mis_fault", 64'(fault_o), 64'd0);
    check("mis_valid", 64'(inst_valid_o), 64'd0);
`endif

    // Randomized traffic with occasional resets.
    fixed_lat = -1;
    for (int i = 0; i < 4000; i++) begin
      next_cycle();
      if ($urandom_range(0, 249) == 0) begin
        rst_n = 1'b0;
        stray_en = 1;
      end else begin
        if (!rst_n) stray_en = 1;
        rst_n = 1'b1;
      end
      hold_flag_i = ($urandom_range(0, 99) < 30);
      jump_flag_i = ($urandom_range(0, 99) < 7);
      imem_gnt_i  = ($urandom_range(0, 99) < 70);
      r = int'($urandom_range(0, 19));
      base = 64'h8000_0000 + (64'($urandom_range(0, 255)) << 2);
      if (r == 0)      jump_addr_i = 64'hFFFF_FFFF_FFFF_FFF0 + (64'($urandom_range(0, 3)) << 2);
      else if (r == 1) jump_addr_i = base | 64'($urandom_range(1, 3));
      else             jump_addr_i = base;
    end
    next_cycle();
    wait_neg();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_8000_0000, first fetch address after reset.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset; synchronous and active-low, sampled on rising clk.
REQ-004 jump_flag_i  input  1  redirect request from execute stage.
REQ-005 jump_addr_i  input  64  redirect target, valid when jump_flag_i=1.
REQ-006 hold_flag_i  input  1  decode stall (load hazard); holds the current instruction.
REQ-007 imem_req_o  output  1  fetch request to instruction memory.
REQ-008 imem_addr_o  output  64  fetch address, valid when imem_req_o=1.
REQ-009 imem_gnt_i  input  1  memory accepts request this cycle.
REQ-010 imem_rvalid_i  input  1  read data valid, at least 1 cycle after the granting cycle.
REQ-011 imem_rdata_i  input  32  fetched instruction.
REQ-012 inst_o  output  32  instruction to decode stage.
REQ-013 inst_addr_o  output  64  address of inst_o.
REQ-014 inst_valid_o  output  1  inst_o/inst_addr_o hold a real fetched instruction.
REQ-015 fault_o  output  1  instruction address misaligned, qualified by inst_valid_o.

Function
REQ-016 The block SHALL hold a 2-entry FIFO of {inst, addr, fault}; inst_valid_o = FIFO not empty; inst_o/inst_addr_o/fault_o = head entry.
REQ-017 When FIFO is empty: inst_o = 32'h0000_0013 (NOP), inst_addr_o = 0, fault_o = 0.
REQ-018 Pop SHALL occur when inst_valid_o=1, hold_flag_i=0 and jump_flag_i=0; hold_flag_i=1 keeps the head unchanged indefinitely.
REQ-019 FSM states: IDLE, REQ, WAIT, DROP; at most one request outstanding.
REQ-020 IDLE: imem_req_o=0; SHALL go to REQ the cycle after reset release.
REQ-021 REQ: imem_req_o=1 only if FIFO occupancy after this cycle's pop is below 2, else 0 (stay in REQ); on imem_gnt_i=1 with imem_req_o=1 -> WAIT and pc += 4.
REQ-022 imem_addr_o = pc; SHALL stay stable while imem_req_o=1 and no grant, except on redirect.
REQ-023 WAIT: on imem_rvalid_i=1 push {imem_rdata_i, address of the granted request, 0} and go to REQ; push and pop in the same cycle are both honoured.
REQ-024 Redirect (jump_flag_i=1): FIFO flushed (empty next cycle), pc <= jump_addr_i, response-pending tracking per REQ-025.
REQ-025 Redirect in WAIT without rvalid, or in REQ with gnt the same cycle -> DROP; in WAIT with rvalid the same cycle -> data discarded, go to REQ; in REQ without gnt -> stay REQ with new address next cycle.
REQ-026 DROP: imem_req_o=0; the next imem_rvalid_i SHALL be discarded (no push), then -> REQ; a further redirect in DROP updates pc only.
REQ-027 Redirect SHALL take priority over hold_flag_i and over any push in the same cycle.
REQ-028 FIFO occupancy SHALL never exceed 2; pc arithmetic is 64-bit modulo 2^64 (wraps 64'hFFFF_FFFF_FFFF_FFFC -> 0).

Reset
REQ-029 On rst_n=0 at a clock edge: pc=RESET_PC, state=IDLE, FIFO empty, imem_req_o=0, inst_valid_o=0, inst_o=NOP, inst_addr_o=0, fault_o=0.
REQ-030 Reset mid-transaction SHALL abandon any outstanding request; an rvalid arriving in IDLE or the first REQ cycle after reset SHALL be ignored.

Configuration
REQ-031 Macro IF_MISALIGN_FAULT_EN defined: if pc[1:0] != 0 in REQ, no request is issued; one entry {NOP, pc, fault=1} is pushed when FIFO has room, then FSM waits in REQ with req low until a redirect.
REQ-032 Macro IF_MISALIGN_FAULT_EN undefined: pc[1:0] ignored (address issued as-is), fault_o tied to 0.

Verification
REQ-033 Reset release, gnt same cycle as req, rvalid 1 cycle later with 32'h00500093 -> imem_addr_o=0x80000000, then inst_valid_o=1, inst_o=0x00500093, inst_addr_o=0x80000000.
REQ-034 hold_flag_i=1 for 5 cycles with memory always granting -> exactly 2 entries buffered, imem_req_o=0 while full, no lost or duplicated instruction after hold release (addresses 0x80000000, +4, +8 in order).
REQ-035 jump_flag_i=1, jump_addr_i=0x80001000 while in WAIT, stale rvalid arrives 3 cycles later -> stale data dropped, next request address 0x80001000, FIFO empty until new response.
REQ-036 jump and rvalid in same cycle, and jump with hold_flag_i=1 -> FIFO empty next cycle, next imem_addr_o = jump target.
REQ-037 pc=0xFFFFFFFFFFFFFFFC granted -> next request address 0x0.
REQ-038 With IF_MISALIGN_FAULT_EN, jump to 0x80000002 -> no imem_req_o, inst_valid_o=1, fault_o=1, inst_addr_o=0x80000002, inst_o=NOP; without macro -> imem_addr_o=0x80000002, fault_o=0.
